dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed data memory. It shares the memory's single address/write/read port between port 0 (CPU load/store unit) and port 1 (secondary master: refill/debug/DMA). It latches one request at a time, drives the memory for the access, and returns read data or an error to the granted port. A round-robin pointer provides fairness, and a ready-timeout guard prevents a hung access.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- TIMEOUT, 15, max ACCESS cycles with mem_ready low before error (≥1)

Ports (clock and reset):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset

Per requester, for x = 0 and x = 1:
- px_req  in  1  access request (level)
- px_we  in  1  1 = store, 0 = load
- px_ctrl  in  3  width code passed to memory (000 byte, 011 byte unsigned, others word)
- px_addr  in  ADDR_WIDTH  byte address
- px_wd  in  DATA_WIDTH  store data
- px_gnt  out  1  one-cycle pulse: request latched
- px_done  out  1  one-cycle pulse: access complete
- px_err  out  1  valid with px_done; access timed out
- px_rd  out  DATA_WIDTH  load data, valid with px_done

Memory side:
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_we  out  1  write enable
- mem_read  out  1  read enable
- mem_ctrl  out  3  width code
- mem_wd  out  DATA_WIDTH  write data
- mem_rd  in  DATA_WIDTH  read data (asynchronous)
- mem_ready  in  1  memory ready
- busy  out  1  high whenever state ≠ IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- In IDLE, the requests are sampled:
  - Only one request: grant that port.
  - Both requests: grant the port ≠ last_gnt.
  - On grant: latch we/ctrl/addr/wd into internal registers, set last_gnt to the granted port, and go to ACCESS.
- In ACCESS:
  - mem_addr/mem_ctrl/mem_wd come from the latched registers.
  - mem_we = latched we and mem_read = ~latched we.
  - If mem_ready is high: capture mem_rd into the rd register (loads only; stores leave rd = 0), clear err, and go to DONE.
  - Otherwise, increment the timeout counter.
  - When the counter reaches TIMEOUT with mem_ready still low: go to DONE with err = 1 and rd = 0.
- In DONE, pulse done (and err) to the owning port, then go to IDLE. No arbitration happens in DONE.
- Outside ACCESS, the memory outputs are all 0 (mem_we = mem_read = 0).
- px_rd/px_err hold their value until the next done for that port. The non-owner's px_done/px_gnt stay 0.
- Requesters must keep req and fields stable until gnt and drop req no later than the done cycle. A req still high when IDLE is re-entered is treated as a new request.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and clears on entry to ACCESS.

## Timing
- Reset values:
  - state = IDLE, last_gnt = 1 (port 0 wins the first tie), counter = 0.
  - All gnt/done/err/busy/mem_we/mem_read = 0.
  - All rd and mem_addr/mem_wd/mem_ctrl = 0.
- Edge E0 samples req in IDLE. In the cycle after E0: px_gnt = 1, memory driven, busy = 1.
- With mem_ready high at E1: px_done = 1 in the cycle after E1. The store commits in memory at E1. Back to IDLE after E2.
- Minimum spacing is one access per 3 cycles. Latency from req sampled to done is 2 cycles.
- mem_we stays high for every ACCESS cycle. Rewriting the same data is harmless.
- A timed-out access drives done + err in the cycle after the (TIMEOUT+1)-th ACCESS edge.
- rst_n assertion mid-ACCESS immediately drops mem_we/mem_read, so no further write commits. The aborted requester gets no done.
- Both requests arriving in the same cycle as done (still in DONE): nothing is sampled until IDLE.

## Test plan
- p0 load: p0_req = 1, addr = 0x10, ctrl = 010, mem_rd = 0xDEADBEEF -> p0_gnt pulse at +1, p0_done at +2 with p0_rd = 0xDEADBEEF, p0_err = 0, mem_read high only in ACCESS.
- p1 store 0x12345678 @0x20, then p1 load @0x20 -> mem_we high exactly in its ACCESS cycle with mem_wd = 0x12345678; the load returns 0x12345678.
- p0 and p1 requesting continuously after reset -> grants alternate p0, p1, p0, p1, every 3 cycles, with no consecutive same-port grant.
- mem_ready held 0, TIMEOUT = 15 -> done and err = 1 after 16 ACCESS cycles, rd = 0, busy = 1 throughout ACCESS.
- rst_n pulsed low during a p0 store ACCESS -> all outputs 0 asynchronously, no p0_done, no memory write at the following edge, and the next tie after release is granted to p0.
- p0 holds req through done -> a second grant to p0 at +3 cycles (treated as a new request).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-ported data memory.
// One request is latched at a time, driven to memory in ACCESS, and answered in DONE.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [2:0]            p0_ctrl,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wd,
   output logic                  p0_gnt,
   output logic                  p0_done,
   output logic                  p0_err,
   output logic [DATA_WIDTH-1:0] p0_rd,

   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [2:0]            p1_ctrl,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wd,
   output logic                  p1_gnt,
   output logic                  p1_done,
   output logic                  p1_err,
   output logic [DATA_WIDTH-1:0] p1_rd,

   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  mem_read,
   output logic [2:0]            mem_ctrl,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd,
   input  logic                  mem_ready,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                state;
   logic                  last_gnt;   // also identifies the owner of the access in flight
   logic                  we_q;
   logic [2:0]            ctrl_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wd_q;
   logic [CNT_W-1:0]      cnt;

   logic                  grant_any;
   logic                  grant_port;
   logic                  timed_out;
   logic                  finish;
   logic                  fin_err;
   logic [DATA_WIDTH-1:0] fin_rd;

   // On a tie the port that did not win last time is chosen.
   assign grant_any  = p0_req | p1_req;
   assign grant_port = (p0_req & p1_req) ? ~last_gnt : p1_req;
   assign timed_out  = (cnt == CNT_W'(TIMEOUT));
   assign finish     = mem_ready | timed_out;
   assign fin_err    = ~mem_ready;
   assign fin_rd     = (mem_ready && !we_q) ? mem_rd : '0;
   assign busy       = (state != S_IDLE);

   // Memory port is decoded from the registered state, so reset silences it at once.
   always_comb begin
      // NOTE: every output gets a default before the if, so no latch is inferred.
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_read = 1'b0;
      mem_ctrl = '0;
      mem_wd   = '0;
      if (state == S_ACCESS) begin
         mem_addr = addr_q;
         mem_we   = we_q;
         mem_read = ~we_q;
         mem_ctrl = ctrl_q;
         mem_wd   = wd_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         last_gnt <= 1'b1;
         we_q     <= 1'b0;
         ctrl_q   <= '0;
         addr_q   <= '0;
         wd_q     <= '0;
         cnt      <= '0;
         p0_gnt   <= 1'b0;
         p1_gnt   <= 1'b0;
         p0_done  <= 1'b0;
         p1_done  <= 1'b0;
         p0_err   <= 1'b0;
         p1_err   <= 1'b0;
         p0_rd    <= '0;
         p1_rd    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; the pulse
         // clears below are overridden by later assignments in the same edge.
         p0_gnt  <= 1'b0;
         p1_gnt  <= 1'b0;
         p0_done <= 1'b0;
         p1_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  last_gnt <= grant_port;
                  we_q     <= grant_port ? p1_we   : p0_we;
                  ctrl_q   <= grant_port ? p1_ctrl : p0_ctrl;
                  addr_q   <= grant_port ? p1_addr : p0_addr;
                  wd_q     <= grant_port ? p1_wd   : p0_wd;
                  cnt      <= '0;
                  p0_gnt   <= ~grant_port;
                  p1_gnt   <= grant_port;
                  state    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (finish) begin
                  if (last_gnt) begin
                     p1_done <= 1'b1;
                     p1_err  <= fin_err;
                     p1_rd   <= fin_rd;
                  end else begin
                     p0_done <= 1'b1;
                     p0_err  <= fin_err;
                     p0_rd   <= fin_rd;
                  end
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: loads, stores, round-robin, timeout, mid-access reset
// and held requests, with a small word memory model on the memory port.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [2:0]  p0_ctrl = '0, p1_ctrl = '0;
   logic [31:0] p0_addr = '0, p0_wd = '0, p1_addr = '0, p1_wd = '0;
   logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
   logic [31:0] p0_rd, p1_rd;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_we, mem_read, busy;
   logic [2:0]  mem_ctrl;
   logic        mem_ready = 1'b1;

   logic [31:0] mem [0:63] = '{default: '0};
   int          wr_count = 0;
   int          checks = 0;
   int          failures = 0;
   int          saved_wr;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_ctrl(p0_ctrl), .p0_addr(p0_addr), .p0_wd(p0_wd),
      .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rd(p0_rd),
      .p1_req(p1_req), .p1_we(p1_we), .p1_ctrl(p1_ctrl), .p1_addr(p1_addr), .p1_wd(p1_wd),
      .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rd(p1_rd),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_read(mem_read), .mem_ctrl(mem_ctrl),
      .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready), .busy(busy)
   );

   // Word memory; address 0x10 is a fixed read-only pattern.
   assign mem_rd = (mem_addr == 32'h10) ? 32'hDEADBEEF : mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we && mem_ready) begin
         mem[mem_addr[7:2]] <= mem_wd;
         wr_count <= wr_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
      chk("rst_done", {p0_done, p1_done, p0_err, p1_err}, 0);
      chk("rst_mem", {mem_we, mem_read}, 0);
      chk("rst_rd", p0_rd | p1_rd, 0);
      chk("rst_addr", mem_addr, 0);
      step();
      rst_n = 1'b1;
      step();

      // p0 load from 0x10
      p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_ctrl = 3'b010; mem_ready = 1;
      step();
      chk("ld_gnt", {p0_gnt, p1_gnt}, 2'b10);
      chk("ld_busy", busy, 1);
      chk("ld_memread", {mem_read, mem_we}, 2'b10);
      chk("ld_addr", mem_addr, 32'h10);
      chk("ld_ctrl", mem_ctrl, 3'b010);
      p0_req = 0;
      step();
      chk("ld_done", {p0_done, p1_done, p0_err}, 3'b100);
      chk("ld_rd", p0_rd, 32'hDEADBEEF);
      chk("ld_gnt_off", p0_gnt, 0);
      chk("ld_memread_off", mem_read, 0);
      step();
      chk("ld_idle", {busy, p0_done}, 0);
      chk("ld_rd_hold", p0_rd, 32'hDEADBEEF);

      // p1 store 0x12345678 @0x20, then load back
      p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wd = 32'h12345678; p1_ctrl = 3'b010;
      step();
      chk("st_gnt", {p0_gnt, p1_gnt}, 2'b01);
      chk("st_we", {mem_we, mem_read}, 2'b10);
      chk("st_wd", mem_wd, 32'h12345678);
      chk("st_addr", mem_addr, 32'h20);
      p1_req = 0;
      step();
      chk("st_done", {p1_done, p1_err, p0_done}, 3'b100);
      chk("st_rd", p1_rd, 0);
      chk("st_we_off", mem_we, 0);
      chk("st_mem", mem[8], 32'h12345678);
      step();
      p1_req = 1; p1_we = 0;
      step();
      chk("ld1_gnt", {p1_gnt, mem_read}, 2'b11);
      p1_req = 0;
      step();
      chk("ld1_done", p1_done, 1);
      chk("ld1_rd", p1_rd, 32'h12345678);
      chk("p0_rd_hold", p0_rd, 32'hDEADBEEF);
      step();

      // Both requesting continuously: grants alternate p0, p1, p0, p1
      p0_req = 1; p0_we = 0; p0_addr = 32'h10;
      p1_req = 1; p1_we = 0; p1_addr = 32'h20;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rr_gnt%0d", i), {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         step();
         chk($sformatf("rr_done%0d", i), {p0_done, p1_done}, (i % 2 == 0) ? 2'b10 : 2'b01);
         step();
         chk($sformatf("rr_idle%0d", i), {busy, p0_gnt, p1_gnt}, 0);
      end
      p0_req = 0; p1_req = 0;

      // Timeout: mem_ready held low, done+err after 16 ACCESS cycles
      mem_ready = 0;
      p0_req = 1;
      step();
      chk("to_gnt", p0_gnt, 1);
      p0_req = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         chk($sformatf("to_wait%0d", i), {busy, mem_read, p0_done}, 3'b110);
      end
      step();
      chk("to_done", {p0_done, p0_err}, 2'b11);
      chk("to_rd", p0_rd, 0);
      chk("to_busy", busy, 1);
      mem_ready = 1;
      step();
      chk("to_err_hold", {busy, p0_err}, 2'b01);

      // Reset during a p0 store ACCESS
      mem_ready = 0;
      p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wd = 32'hCAFEF00D;
      step();
      chk("rs_gnt", {p0_gnt, mem_we}, 2'b11);
      saved_wr = wr_count;
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async", {busy, mem_we, mem_read, p0_gnt, p0_done, p0_err}, 0);
      chk("rs_addr", mem_addr, 0);
      mem_ready = 1;
      step();
      chk("rs_nowrite", mem[12], 0);
      chk("rs_wrcount", wr_count, saved_wr);
      chk("rs_nodone", p0_done, 0);

      // Release with a tie: p0 wins; p0 then holds req through done
      rst_n = 1'b1;
      p1_req = 1; p1_we = 0;
      step();
      chk("rs_tie", {p0_gnt, p1_gnt}, 2'b10);
      p1_req = 0;
      step();
      chk("hold_done", {p0_done, p0_err}, 2'b10);
      chk("hold_mem", mem[12], 32'hCAFEF00D);
      step();
      chk("hold_idle", {busy, p0_gnt}, 0);
      step();
      chk("hold_regnt", {p0_gnt, p1_gnt, busy}, 3'b101);
      p0_req = 0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
